// File: rtl/reg_memory_pkg.sv
// reg_memory_pkg: shared sizing defaults for the decode-stage register file
package reg_memory_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int SHAMT    = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;
endpackage

// File: rtl/reg_memory_shl.sv
// shl: fixed left shift that turns a word-granular immediate into a byte offset
module shl #(
    parameter int DATA_W = reg_memory_pkg::DATA_W,
    parameter int SHAMT  = reg_memory_pkg::SHAMT
) (
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] y
);
    assign y = {a[DATA_W-1-SHAMT:0], {SHAMT{1'b0}}};
endmodule

// File: rtl/reg_memory.sv
// reg_memory: 2**ADDR_W x DATA_W register file with two async read ports,
// one sync write port, a zero/sign test on port 1 and a branch-offset shifter
module reg_memory
    import reg_memory_pkg::*;
#(
    parameter int DATA_W = reg_memory_pkg::DATA_W,
    parameter int ADDR_W = reg_memory_pkg::ADDR_W,
    parameter int SHAMT  = reg_memory_pkg::SHAMT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data_input,
    input  logic              data_input_on,
    input  logic [DATA_W-1:0] imm_extend,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              cmp_result,
    output logic              cmp_neg,
    output logic [DATA_W-1:0] branch_dir
);
    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [N];

    // no write-through: a same-cycle read sees the old value until the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs <= '{default: '0};
        else if (data_input_on) regs[rd] <= data_input;
    end

    assign data1      = regs[ra];
    assign data2      = regs[rb];
    assign cmp_result = (data1 == '0);
    assign cmp_neg    = data1[DATA_W-1];

    shl #(.DATA_W(DATA_W), .SHAMT(SHAMT)) u_shl (
        .a(imm_extend),
        .y(branch_dir)
    );
endmodule

// File: tb/tb_reg_memory.sv
// tb_reg_memory: randomized scoreboard bench for reg_memory against an array model
module tb_reg_memory;
    logic        clk = 0;
    logic        rst = 1;
    logic [3:0]  ra = 0, rb = 0, rd = 0;
    logic [31:0] data_input = 0, imm_extend = 0;
    logic        data_input_on = 0;
    logic [31:0] data1, data2, branch_dir;
    logic        cmp_result, cmp_neg;
    logic        chk = 0;

    typedef struct {
        logic [31:0] d1, d2, bd;
        logic        z, n;
        string       tag;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m [16];
    int          tests = 0, errors = 0;

    reg_memory dut (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rd(rd),
        .data_input(data_input), .data_input_on(data_input_on),
        .imm_extend(imm_extend), .data1(data1), .data2(data2),
        .cmp_result(cmp_result), .cmp_neg(cmp_neg), .branch_dir(branch_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: the DUT presents a fresh read every cycle flagged by chk
    initial forever begin
        @(negedge clk);
        if (chk) begin
            if (q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL underflow: got empty queue expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.tag, ".data1"}, data1, e.d1);
                check({e.tag, ".data2"}, data2, e.d2);
                check({e.tag, ".cmp_result"}, {31'b0, cmp_result}, {31'b0, e.z});
                check({e.tag, ".cmp_neg"}, {31'b0, cmp_neg}, {31'b0, e.n});
                check({e.tag, ".branch_dir"}, branch_dir, e.bd);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m[i] = 0;
    endtask

    // called just after a rising edge; returns just after the next one
    task automatic cyc(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                       input logic [31:0] din, input logic we, input logic [31:0] imm,
                       input logic r, input string tag);
        exp_t e;
        ra = a; rb = b; rd = d; data_input = din; data_input_on = we; imm_extend = imm; rst = r;
        if (r) model_clear();
        e.d1 = m[a];
        e.d2 = m[b];
        e.z = (m[a] == 0);
        e.n = (m[a] >= 32'h8000_0000);
        e.bd = imm * 32'd4;
        e.tag = tag;
        q.push_back(e);
        chk = 1;
        @(posedge clk);
        if (!r && we) m[d] = din;
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1;
        model_clear();
        #1 rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        cyc(4'd0, 4'd15, 4'd0, 32'h0, 1'b1, 32'h0, 1'b1, "reset");
        cyc(4'd3, 4'd3, 4'd3, 32'h0000_00A5, 1'b1, 32'h0000_0004, 1'b0, "wr_pre");
        cyc(4'd3, 4'd3, 4'd5, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, "wr_post");
        cyc(4'd5, 4'd3, 4'd7, 32'h8000_0001, 1'b1, 32'h4000_0001, 1'b0, "we_low");
        cyc(4'd7, 4'd0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, "cmp_neg");
        cyc(4'd0, 4'd7, 4'd2, 32'hDEAD_BEEF, 1'b1, 32'h1, 1'b0, "cmp_zero");
        cyc(4'd2, 4'd7, 4'd2, 32'h5555_5555, 1'b1, 32'h2, 1'b1, "rst_mid");
        cyc(4'd2, 4'd3, 4'd2, 32'h0000_1234, 1'b1, 32'h0, 1'b0, "post_rst");
        cyc(4'd2, 4'd7, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, "post_rst2");
        for (int i = 0; i < 16; i++)
            cyc(4'(i), 4'(15 - i), 4'(i), $urandom | 32'h1, 1'b1, $urandom, 1'b0, "fill");
        pulse_rst();
        for (int i = 0; i < 16; i++)
            cyc(4'(i), 4'(15 - i), 4'(i), $urandom, 1'b0, $urandom, 1'b0, "pulse_clr");
        for (int i = 0; i < 400; i++)
            cyc(4'($urandom), 4'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                1'($urandom), $urandom, $urandom_range(0, 19) == 0, "rand");
        chk = 0;
        repeat (2) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
